spi_flash_seq: RTL

Hardware SPI-flash read sequencer for the Mecrisp-Ice J1 system. It replaces bit-banged flash access through the PIOS register. Two uses:
- Streaming reads: issues opcode 0x03 plus a 24-bit address and pushes the returned bytes into a small RX FIFO, stalling SCK when the FIFO is full.
- Raw transfers: sends single full-duplex bytes under software-held chip select, for other flash commands.

It sits on the J1 IO bus. Top decodes a 4-word window into `wr`/`rd`/`addr` and ORs `rdata` into `io_din`. The block drives the flash SPI pins directly.

---
 rtl/spi_flash_seq.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_seq.sv
// spi_flash_seq: SPI-flash read sequencer for the J1 IO bus.
// Streams opcode 0x03 + 24-bit address reads into a small RX FIFO, stalling
// SCK while the FIFO is full; also runs single raw bytes under software CS.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no transfer; cs_n follows the raw CS hold bit
// S_CMD     | shifting 0x03 and A23..A0 (32 bits) out on MOSI
// S_STREAM  | receiving bytes into the FIFO, waiting with SCK low when full
// S_RAW     | one full-duplex byte under raw CS hold
// S_RELEASE | cs_n high, SCK low for CLKDIV cycles before returning to idle
module spi_flash_seq #(
   parameter int CLKDIV     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic        wr,
   input  logic        rd,
   input  logic [1:0]  addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        spi_sck,
   output logic        spi_cs_n,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic        busy
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [7:0]  DIV_LAST = 8'(CLKDIV - 1);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_STREAM, S_RAW, S_RELEASE} state_t;

   state_t        state_q, state_d;
   logic [7:0]    div_q, div_d;
   logic          sck_q, sck_d;
   logic          cs_n_q, cs_n_d;
   logic          hold_q, hold_d;
   logic [5:0]    bit_q, bit_d;
   logic [8:0]    byte_q, byte_d;
   logic [31:0]   tx_q, tx_d;
   logic [6:0]    rx_q, rx_d;
   logic [23:0]   addr_q, addr_d;
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [7:0]    mem_q [FIFO_DEPTH];

   logic       fifo_full, fifo_empty, push, push_ok, pop, flush, stall;
   logic       wr_data, wr_ctrl, wr_lo, wr_go, abort;
   logic [7:0] push_byte;

   assign fifo_full  = (cnt_q == FULL_CNT);
   assign fifo_empty = (cnt_q == '0);
   assign pop        = rd && (addr == 2'd0) && !fifo_empty;
   assign push_ok    = push && (!fifo_full || pop);
   assign push_byte  = {rx_q, spi_miso};
   assign wr_data    = wr && (addr == 2'd0);
   assign wr_ctrl    = wr && (addr == 2'd1);
   assign wr_lo      = wr && (addr == 2'd2);
   assign wr_go      = wr && (addr == 2'd3);
   assign abort      = wr_ctrl && wdata[1];
   // A new byte only starts once the FIFO has room for it.
   assign stall      = (state_q == S_STREAM) && (bit_q == 6'd0) && !sck_q && fifo_full;

   assign busy     = (state_q != S_IDLE);
   assign spi_sck  = sck_q;
   assign spi_cs_n = cs_n_q;
   assign spi_mosi = (state_q == S_CMD || state_q == S_RAW) ? tx_q[31] : 1'b0;

   // Register read mux; DATA reads of an empty FIFO return zero.
   always_comb begin
      rdata = 16'h0000;
      case (addr)
         2'd0:    rdata = fifo_empty ? 16'h0000 : {8'h00, mem_q[rp_q]};
         2'd1:    rdata = {12'd0, ~cs_n_q, fifo_full, ~fifo_empty, busy};
         default: rdata = 16'h0000;
      endcase
   end

   // Sequencer next state: SCK divider, shifting, byte accounting, aborts.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      sck_d   = sck_q;
      hold_d  = hold_q;
      bit_d   = bit_q;
      byte_d  = byte_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      addr_d  = addr_q;
      push    = 1'b0;
      flush   = 1'b0;

      if (wr_lo) addr_d[15:0]  = wdata;
      if (wr_go) addr_d[23:16] = wdata[7:0];

      case (state_q)
         S_IDLE: begin
            if (wr_ctrl) hold_d = wdata[0];
            if (wr_go && !hold_q) begin
               state_d = S_CMD;
               tx_d    = {8'h03, addr_d};
               byte_d  = {wdata[15:8] == 8'h00, wdata[15:8]};
               flush   = 1'b1;
               div_d   = DIV_LAST;
               sck_d   = 1'b0;
               bit_d   = 6'd0;
            end else if (wr_data && hold_q && !fifo_full) begin
               state_d = S_RAW;
               tx_d    = {wdata[7:0], 24'h000000};
               div_d   = DIV_LAST;
               sck_d   = 1'b0;
               bit_d   = 6'd0;
            end
         end
         S_CMD, S_STREAM, S_RAW: begin
            if (state_q == S_RAW && bit_q == 6'd8) begin
               // Raw byte already pushed: finish without waiting for the last fall.
               state_d = S_IDLE;
               sck_d   = 1'b0;
            end else if (stall) begin
               div_d = DIV_LAST;
            end else if (div_q != 8'd0) begin
               div_d = div_q - 8'd1;
            end else begin
               div_d = DIV_LAST;
               sck_d = !sck_q;
               if (!sck_q) begin
                  rx_d  = push_byte[6:0];
                  bit_d = bit_q + 6'd1;
                  if (state_q != S_CMD && bit_q == 6'd7) begin
                     push = 1'b1;
                     if (state_q == S_STREAM) byte_d = byte_q - 9'd1;
                  end
               end else begin
                  tx_d = {tx_q[30:0], 1'b0};
                  if (state_q == S_CMD && bit_q == 6'd32) begin
                     state_d = S_STREAM;
                     bit_d   = 6'd0;
                  end else if (state_q == S_STREAM && bit_q == 6'd8) begin
                     bit_d = 6'd0;
                     if (byte_q == 9'd0) state_d = S_RELEASE;
                  end
               end
            end
         end
         S_RELEASE: begin
            sck_d = 1'b0;
            if (div_q == 8'd0) state_d = S_IDLE;
            else               div_d   = div_q - 8'd1;
         end
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d = S_IDLE;
         sck_d   = 1'b0;
         hold_d  = 1'b0;
         bit_d   = 6'd0;
         flush   = 1'b1;
         push    = 1'b0;
      end
   end

   // Chip select is registered so it changes on the same edge as the state.
   always_comb begin
      cs_n_d = !((state_d == S_CMD) || (state_d == S_STREAM) || (state_d == S_RAW) ||
                 ((state_d == S_IDLE) && hold_d));
   end

   // FIFO pointers and occupancy; flush wins over push/pop.
   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (flush) begin
         wp_d  = '0;
         rp_d  = '0;
         cnt_d = '0;
      end else begin
         if (push_ok) wp_d = wp_q + AW'(1);
         if (pop)     rp_d = rp_q + AW'(1);
         cnt_d = cnt_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);
      end
   end

   // FIFO storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem_q[wp_q] <= push_byte;
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         state_q <= S_IDLE;
         div_q   <= 8'd0;
         sck_q   <= 1'b0;
         cs_n_q  <= 1'b1;
         hold_q  <= 1'b0;
         bit_q   <= 6'd0;
         byte_q  <= 9'd0;
         tx_q    <= 32'd0;
         rx_q    <= 7'd0;
         addr_q  <= 24'd0;
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         sck_q   <= sck_d;
         cs_n_q  <= cs_n_d;
         hold_q  <= hold_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         addr_q  <= addr_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
